// File: rtl/line_clear_engine.sv
// Line-clear engine: after a piece locks, walks the playfield grid RAM from the
// bottom row upward, removes every full row by shifting the rows above it down
// one step, zero-fills the top row, and reports how many rows were removed.
// Port B (read) is registered in the RAM, so every read costs one extra cycle.
module line_clear_engine #(
    parameter int COLS  = 10,
    parameter int ROWS  = 16,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] lines_cleared,
    output logic [7:0]       mem_addr_a,
    output logic [7:0]       mem_data_a,
    output logic             mem_we_a,
    output logic [7:0]       mem_addr_b,
    input  logic [7:0]       mem_q_b
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SC_RD  = 3'd1,
        SC_CHK = 3'd2,
        SH_RD  = 3'd3,
        SH_WR  = 3'd4,
        CLR    = 3'd5,
        DONE   = 3'd6
    } state_t;

    localparam logic [3:0] LAST_COL = 4'(COLS - 1);
    localparam logic [3:0] LAST_ROW = 4'(ROWS - 1);

    state_t           state_q, state_d;
    logic [3:0]       row_q, row_d;   // row currently being scanned
    logic [3:0]       r_q, r_d;       // destination row while shifting down
    logic [3:0]       col_q, col_d;   // column cursor shared by scan/shift/clear
    logic [CNT_W-1:0] lc_q, lc_d;     // rows removed so far

    // State and cursor registers; reset forces IDLE so no write can follow it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            row_q   <= '0;
            r_q     <= '0;
            col_q   <= '0;
            lc_q    <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            r_q     <= r_d;
            col_q   <= col_d;
            lc_q    <= lc_d;
        end
    end

    // Next-state and cursor updates for scan, shift and clear phases.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        r_d     = r_q;
        col_d   = col_q;
        lc_d    = lc_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    row_d   = LAST_ROW;
                    col_d   = '0;
                    lc_d    = '0;
                    state_d = SC_RD;
                end
            end
            SC_RD: begin
                state_d = SC_CHK;
            end
            SC_CHK: begin
                if (mem_q_b == 8'd0) begin
                    // First empty cell: this row stays, move one row up.
                    if (row_q == 4'd0) begin
                        state_d = DONE;
                    end else begin
                        row_d   = row_q - 4'd1;
                        col_d   = '0;
                        state_d = SC_RD;
                    end
                end else if (col_q == LAST_COL) begin
                    // Row is full: drop everything above it, or just wipe row 0.
                    lc_d    = lc_q + CNT_W'(1);
                    r_d     = row_q;
                    col_d   = '0;
                    state_d = (row_q == 4'd0) ? CLR : SH_RD;
                end else begin
                    col_d   = col_q + 4'd1;
                    state_d = SC_RD;
                end
            end
            SH_RD: begin
                state_d = SH_WR;
            end
            SH_WR: begin
                if (col_q != LAST_COL) begin
                    col_d   = col_q + 4'd1;
                    state_d = SH_RD;
                end else if (r_q > 4'd1) begin
                    r_d     = r_q - 4'd1;
                    col_d   = '0;
                    state_d = SH_RD;
                end else begin
                    col_d   = '0;
                    state_d = CLR;
                end
            end
            CLR: begin
                if (col_q == LAST_COL) begin
                    // Re-scan the same row: it now holds what used to sit above it.
                    col_d   = '0;
                    state_d = SC_RD;
                end else begin
                    col_d   = col_q + 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // RAM port drive and status outputs decoded from the current state.
    always_comb begin
        mem_addr_a    = 8'd0;
        mem_data_a    = 8'd0;
        mem_we_a      = 1'b0;
        mem_addr_b    = 8'd0;
        busy          = (state_q != IDLE) && (state_q != DONE);
        done          = (state_q == DONE);
        lines_cleared = lc_q;
        case (state_q)
            SC_RD: begin
                mem_addr_b = {row_q, col_q};
            end
            SH_RD: begin
                mem_addr_b = {r_q - 4'd1, col_q};
            end
            SH_WR: begin
                mem_addr_a = {r_q, col_q};
                mem_data_a = mem_q_b;
                mem_we_a   = 1'b1;
            end
            CLR: begin
                mem_addr_a = {4'd0, col_q};
                mem_we_a   = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_line_clear_engine.sv
// Bench for line_clear_engine: behavioural grid RAM, a row-compaction reference
// model, and a scoreboard that checks each completed operation at its done pulse.
`timescale 1ns/1ps
module tb_line_clear_engine;

    localparam int COLS  = 10;
    localparam int ROWS  = 16;
    localparam int CNT_W = 5;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] lines_cleared;
    logic [7:0]       mem_addr_a;
    logic [7:0]       mem_data_a;
    logic             mem_we_a;
    logic [7:0]       mem_addr_b;
    logic [7:0]       mem_q_b = 8'd0;

    line_clear_engine #(.COLS(COLS), .ROWS(ROWS), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .lines_cleared(lines_cleared), .mem_addr_a(mem_addr_a),
        .mem_data_a(mem_data_a), .mem_we_a(mem_we_a),
        .mem_addr_b(mem_addr_b), .mem_q_b(mem_q_b)
    );

    always #5 clk = ~clk;

    typedef logic [255:0][7:0] grid_t;

    typedef struct {
        int    lc;
        int    cyc;
        int    wr;
        int    t0;
        grid_t g;
    } exp_t;

    logic [7:0] mem [256];
    exp_t       sb [$];
    exp_t       e;
    int         cyc_cnt = 0;
    int         wr_seen = 0;
    int         bad_col = 0;
    int         n_tests = 0;
    int         n_fail  = 0;
    int         gbad;

    // Grid RAM: registered read (old data), write on port A.
    always @(posedge clk) begin
        mem_q_b <= mem[mem_addr_b];
        if (mem_we_a) mem[mem_addr_a] = mem_data_a;
    end

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: tallies writes and checks a finished operation against the scoreboard.
    always @(negedge clk) begin
        if (!reset) begin
            if (mem_we_a) begin
                wr_seen++;
                if (int'(mem_addr_a[3:0]) >= COLS) bad_col++;
            end
            if (int'(mem_addr_b[3:0]) >= COLS) bad_col++;
            if (done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("lines_cleared", int'(lines_cleared), e.lc);
                    chk("done_latency", cyc_cnt - e.t0, e.cyc);
                    chk("write_count", wr_seen, e.wr);
                    chk("column_range", bad_col, 0);
                    chk("busy_in_done", int'(busy), 0);
                    gbad = -1;
                    for (int i = 0; i < 256; i++)
                        if (gbad < 0 && mem[i] !== e.g[i]) gbad = i;
                    chk("grid_first_bad_cell", gbad, -1);
                end
            end
        end
    end

    task automatic load(input grid_t g);
        for (int i = 0; i < 256; i++) mem[i] = g[i];
    endtask

    // Reference: full rows vanish, surviving rows pack to the bottom in order,
    // freed rows at the top become empty. Timing comes from per-cell costs.
    task automatic run_op(input grid_t g, input bit poke);
        exp_t  x;
        grid_t o;
        int    nf, pos, fe, keep;
        load(g);
        o = g;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) o[r*16+c] = 8'd0;
        nf = 0; x.cyc = 0; x.wr = 0; keep = ROWS - 1;
        for (int i = ROWS - 1; i >= 0; i--) begin
            fe = -1;
            for (int c = 0; c < COLS; c++)
                if (fe < 0 && g[i*16+c] == 8'd0) fe = c;
            pos = i + nf;
            if (fe < 0) begin
                x.cyc += 2*COLS + 2*COLS*pos + COLS;
                x.wr  += COLS*pos + COLS;
                nf++;
            end else begin
                x.cyc += 2*(fe + 1);
                for (int c = 0; c < COLS; c++) o[keep*16+c] = g[i*16+c];
                keep--;
            end
        end
        x.cyc += 2*nf;
        x.lc = nf;
        x.g  = o;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        x.t0 = cyc_cnt;
        wr_seen = 0;
        bad_col = 0;
        sb.push_back(x);
        chk("busy_after_accept", int'(busy), 1);
        if (poke) begin
            repeat ($urandom_range(1, 10)) @(negedge clk);
            start = 1'b1;
            @(negedge clk) start = 1'b0;
        end
        for (int k = 0; k < 20000 && sb.size() != 0; k++) @(negedge clk);
        if (sb.size() != 0) begin
            chk("done_timeout", 0, 1);
            sb.delete();
        end
        @(negedge clk);
    endtask

    grid_t g;
    int    kind;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'd0;
        repeat (3) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_we", int'(mem_we_a), 0);
        chk("rst_lc", int'(lines_cleared), 0);
        chk("rst_addrs", int'({mem_addr_a, mem_addr_b, mem_data_a}), 0);
        reset = 1'b0;
        @(negedge clk);

        // Empty grid
        g = '0;
        run_op(g, 1'b0);

        // Row 15 full, row 14 partly filled
        g = '0;
        for (int c = 0; c < COLS; c++) g[15*16+c] = 8'd3;
        for (int c = 0; c < 5; c++) g[14*16+c] = 8'd5;
        run_op(g, 1'b0);

        // Rows 12..15 full, single cell at {11,0}
        g = '0;
        for (int r = 12; r < 16; r++)
            for (int c = 0; c < COLS; c++) g[r*16+c] = 8'(r);
        g[11*16] = 8'd7;
        run_op(g, 1'b0);

        // Rows 15 and 13 full, row 14 half full
        g = '0;
        for (int c = 0; c < COLS; c++) begin
            g[15*16+c] = 8'd1;
            g[13*16+c] = 8'd2;
        end
        for (int c = 0; c < COLS/2; c++) g[14*16+c] = 8'd9;
        run_op(g, 1'b0);

        // Only row 0 full
        g = '0;
        for (int c = 0; c < COLS; c++) g[c] = 8'd4;
        run_op(g, 1'b0);

        // Reset during a shift, then a normal operation
        g = '0;
        for (int c = 0; c < COLS; c++) g[15*16+c] = 8'd6;
        g[3*16+2] = 8'd8;
        load(g);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (24) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_we", int'(mem_we_a), 0);
        chk("midrst_done", int'(done), 0);
        reset = 1'b0;
        @(negedge clk);
        run_op(g, 1'b0);

        // Randomised grids, with stray start pulses while busy
        for (int t = 0; t < 20; t++) begin
            g = '0;
            for (int r = 0; r < ROWS; r++) begin
                kind = $urandom_range(0, 3);
                for (int c = 0; c < 16; c++) begin
                    if (c >= COLS)      g[r*16+c] = 8'($urandom_range(0, 255));
                    else if (kind == 0) g[r*16+c] = 8'($urandom_range(1, 255));
                    else if (kind == 1) g[r*16+c] = 8'($urandom_range(0, 3));
                    else if (kind == 2) g[r*16+c] = 8'd0;
                    else                g[r*16+c] = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'd1;
                end
                if (kind == 1 || kind == 3) g[r*16+$urandom_range(0, COLS-1)] = 8'd0;
            end
            run_op(g, t[0]);
        end

        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
